// File: rtl/wb_pkg.sv
// Shared types and constants for the multi-lane writeback/commit stage.
// Lane count limits, PC increments and the per-lane commit record live here.
package wb_pkg;

   localparam int unsigned MIN_LANES = 1;
   localparam int unsigned MAX_LANES = 4;
   localparam int unsigned XLEN      = 32;

   localparam logic [XLEN-1:0] PC_INC_HALF = 32'd2;
   localparam logic [XLEN-1:0] PC_INC_FULL = 32'd4;

   typedef logic [XLEN-1:0] reg_data_t;
   typedef logic [XLEN-1:0] program_counter_t;
   typedef logic [4:0]      reg_idx_t;
   typedef logic [1:0]      program_state_t;

   typedef enum logic [2:0] {
      EXCEPT_NONE,
      EXCEPT_FLUSH,
      EXCEPT_MISPRED,
      EXCEPT_ILLEGAL,
      EXCEPT_ECALL
   } except_code_t;

   typedef enum logic [1:0] {
      RD_NONE,
      RD_REG,
      RD_REG_AND_PC,
      RD_FLUSH
   } rd_sel_t;

   typedef struct packed {
      logic         valid;
      except_code_t code;
   } except_t;

   typedef struct packed {
      reg_idx_t idx;
   } rd_t;

   typedef struct packed {
      rd_sel_t rd_sel;
      rd_t     rd;
   } decode_t;

   typedef struct packed {
      logic             valid;
      program_counter_t pc;
      logic             half;
      except_t          except;
      decode_t          decode;
   } issued_instr_t;

   typedef struct packed {
      logic      valid;
      reg_idx_t  idx;
      reg_data_t data;
   } int_arch_reg_wb_t;

   typedef struct packed {
      logic             commit;
      logic             is_event;
      logic             pc_alter;
      int_arch_reg_wb_t wb;
   } lane_rec_t;

   function automatic program_counter_t pc_next(input program_counter_t pc, input logic half);
      return pc + (half ? PC_INC_HALF : PC_INC_FULL);
   endfunction

endpackage

// File: rtl/wb_lane_eval.sv
// Per-lane combinational evaluation: event detection, redirect target and
// the raw (pre-squash, pre-WAW) register write for one retiring instruction.
module wb_lane_eval
   import wb_pkg::*;
(
   input  logic             i_active,
   input  issued_instr_t    i_instr,
   input  reg_data_t        i_data,
   output lane_rec_t        o_rec,
   output program_counter_t o_target
);

   logic valid;
   logic exc_redirect;
   logic writes_reg;

   assign valid        = i_active && i_instr.valid;
   assign exc_redirect = i_instr.except.valid &&
                         (i_instr.except.code == EXCEPT_FLUSH ||
                          i_instr.except.code == EXCEPT_MISPRED);
   assign writes_reg   = (i_instr.decode.rd_sel == RD_REG ||
                          i_instr.decode.rd_sel == RD_REG_AND_PC) &&
                         (i_instr.decode.rd.idx != '0);

   always_comb begin
      o_rec          = '0;
      o_target       = '0;
      o_rec.commit   = valid;
      o_rec.is_event = valid && (exc_redirect || i_instr.decode.rd_sel == RD_FLUSH);
      o_rec.pc_alter = valid && exc_redirect;
      if (o_rec.pc_alter) begin
         o_target = (i_instr.except.code == EXCEPT_MISPRED) ? i_data
                                                            : pc_next(i_instr.pc, i_instr.half);
      end
      if (valid && writes_reg) begin
         o_rec.wb.valid = 1'b1;
         o_rec.wb.idx   = i_instr.decode.rd.idx;
         o_rec.wb.data  = (i_instr.decode.rd_sel == RD_REG_AND_PC) ? pc_next(i_instr.pc, i_instr.half)
                                                                   : i_data;
      end
   end

endmodule

// File: rtl/writeback_multi.sv
// N-lane in-order writeback/commit: oldest-event priority with younger-lane
// squash, same-cycle WAW masking, post-flush shadow and cycle/instret counters.
module writeback_multi
   import wb_pkg::*;
#(
   parameter int unsigned NUM_LANES    = 2,
   parameter int unsigned FLUSH_SHADOW = 1,
   parameter int unsigned CNT_W        = 64
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  program_state_t   i_ps,
   input  issued_instr_t    i_instr      [NUM_LANES],
   input  reg_data_t        i_data       [NUM_LANES],
   output int_arch_reg_wb_t o_int_reg_wb [NUM_LANES],
   output logic             o_flush,
   output logic             o_ps_alter,
   output program_state_t   o_ps,
   output logic             o_pc_alter,
   output program_counter_t o_pc,
   output logic [CNT_W-1:0] o_cycle_count,
   output logic [CNT_W-1:0] o_instret
);

   localparam int unsigned SHADOW_W = $clog2(FLUSH_SHADOW + 1);

   logic [SHADOW_W-1:0] shadow_cnt;
   logic [SHADOW_W-1:0] shadow_nxt;
   logic                active;
   lane_rec_t           rec     [NUM_LANES];
   program_counter_t    target  [NUM_LANES];
   int_arch_reg_wb_t    wb_nxt  [NUM_LANES];
   logic [NUM_LANES-1:0] commit;
   logic                found;
   logic                flush_nxt;
   logic                pc_alter_nxt;
   program_counter_t    pc_nxt;
   logic [CNT_W-1:0]    retire_cnt;
   logic                unused_ps;

   assign active    = (shadow_cnt == '0);
   assign unused_ps = ^i_ps;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      wb_lane_eval u_eval (
         .i_active (active),
         .i_instr  (i_instr[g]),
         .i_data   (i_data[g]),
         .o_rec    (rec[g]),
         .o_target (target[g])
      );
   end

   // Walk oldest to youngest; the first event closes the bundle.
   always_comb begin
      found        = 1'b0;
      flush_nxt    = 1'b0;
      pc_alter_nxt = 1'b0;
      pc_nxt       = '0;
      retire_cnt   = '0;
      commit       = '0;
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
         if (!found && rec[k].commit) begin
            commit[k]  = 1'b1;
            retire_cnt = retire_cnt + CNT_W'(1);
            if (rec[k].is_event) begin
               found        = 1'b1;
               flush_nxt    = 1'b1;
               pc_alter_nxt = rec[k].pc_alter;
               pc_nxt       = target[k];
            end
         end
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
         wb_nxt[k] = '0;
         if (commit[k] && rec[k].wb.valid) begin
            wb_nxt[k] = rec[k].wb;
            for (int unsigned j = k + 1; j < NUM_LANES; j++) begin
               if (commit[j] && rec[j].wb.valid && rec[j].wb.idx == rec[k].wb.idx) begin
                  wb_nxt[k] = '0;
               end
            end
         end
      end
   end

   always_comb begin
      shadow_nxt = shadow_cnt;
      if (flush_nxt) begin
         shadow_nxt = SHADOW_W'(FLUSH_SHADOW);
      end else if (shadow_cnt != '0) begin
         shadow_nxt = shadow_cnt - SHADOW_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         shadow_cnt    <= '0;
         o_flush       <= 1'b0;
         o_pc_alter    <= 1'b0;
         o_pc          <= '0;
         o_cycle_count <= '0;
         o_instret     <= '0;
         for (int unsigned k = 0; k < NUM_LANES; k++) begin
            o_int_reg_wb[k] <= '0;
         end
      end else begin
         shadow_cnt    <= shadow_nxt;
         o_flush       <= flush_nxt;
         o_pc_alter    <= pc_alter_nxt;
         o_pc          <= pc_nxt;
         o_cycle_count <= o_cycle_count + CNT_W'(1);
         o_instret     <= o_instret + retire_cnt;
         for (int unsigned k = 0; k < NUM_LANES; k++) begin
            o_int_reg_wb[k] <= wb_nxt[k];
         end
      end
   end

   assign o_ps_alter = 1'b0;
   assign o_ps       = '0;

endmodule

// File: doc/writeback_multi.md
Name: writeback_multi

Overview:
- N-lane in-order writeback/commit stage. Sits after Mem and drives the RegFile, the global flush, and PS/PC redirect.
- Generalises single-lane writeback in four ways: lane count, a configurable post-flush shadow, intra-bundle squash, and same-cycle WAW suppression.
- Keeps architectural cycle and instret counters.
- Lane 0 is always the oldest instruction in the bundle.

Parameters:
- NUM_LANES, 2, number of instructions retired per cycle (1..4).
- FLUSH_SHADOW, 1, cycles after a flush during which all inputs are ignored (>=1).
- CNT_W, 64, width of the cycle and instret counters.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_ps  in  program_state_t  current program state.
- i_instr  in  issued_instr_t[NUM_LANES]  instructions from Mem.
- i_data  in  reg_data_t[NUM_LANES]  result data from Mem; for a mispredict this is the redirect target.
- o_int_reg_wb  out  int_arch_reg_wb_t[NUM_LANES]  per-lane register-file writes.
- o_flush  out  1  pipeline flush.
- o_ps_alter  out  1  PS update valid.
- o_ps  out  program_state_t  new PS.
- o_pc_alter  out  1  PC redirect valid.
- o_pc  out  program_counter_t  redirect target.
- o_cycle_count  out  CNT_W  cycles since reset.
- o_instret  out  CNT_W  retired instruction count.

Behaviour:
- Reset:
  - Asynchronous on i_rst_n low.
  - All outputs, the shadow counter and both counters go to 0.
  - Release takes effect on the first rising i_clk after deassertion.
- Latency: all outputs are registered. A bundle presented in cycle T is reflected at the outputs in cycle T+1.
- Shadow counter (shadow_cnt):
  - Loaded with FLUSH_SHADOW when o_flush is registered high.
  - Decrements each cycle while nonzero.
  - While shadow_cnt != 0: all lanes are treated invalid and next-cycle outputs are 0, except the counters.
  - With FLUSH_SHADOW=1 the block matches single-lane flush semantics.
- Event detection, lane k is an event lane when:
  - it is valid, and
  - its except.valid is set with code EXCEPT_FLUSH or EXCEPT_MISPRED, or its decode.rd_sel == RD_FLUSH.
- Bundle resolution:
  - e = lowest-index event lane.
  - Lanes 0..e commit.
  - Lanes >e are squashed: no register write and not counted.
  - If there is no event lane, all valid lanes commit.
- Redirect, driven by lane e:
  - EXCEPT_FLUSH: o_pc_alter=1, o_pc = pc_e + (half_e ? 2 : 4).
  - EXCEPT_MISPRED: o_pc_alter=1, o_pc = i_data[e].
  - RD_FLUSH with no exception: o_flush=1, o_pc_alter=0, o_pc=0.
  - Any event: o_flush=1.
  - o_ps_alter and o_ps are held 0 in this revision; the ports are reserved.
- Register write for lane k, valid when all hold:
  - the lane commits;
  - rd.idx != 0;
  - rd_sel is RD_REG or RD_REG_AND_PC.
- Register write data:
  - RD_REG_AND_PC: pc + (half ? 2 : 4).
  - Otherwise: i_data[k].
- WAW suppression:
  - If a younger committing lane j>k writes the same nonzero idx, lane k's write valid is forced to 0.
  - Only the youngest same-index write reaches the RegFile.
- An event lane that also writes a register (e.g. a mispredicting JAL) still commits its own write.
- Counters:
  - o_cycle_count increments by 1 every cycle out of reset.
  - o_instret adds the popcount of committing lanes; it adds 0 during the shadow.
  - Both wrap modulo 2^CNT_W.
- Simultaneous events: only the oldest event lane acts, and younger events are discarded.
- A flush arriving on the first cycle after a shadow expires is accepted normally.
- Reset asserted mid-shadow clears the shadow immediately.

Decomposition:
- Package wb_pkg holds:
  - the per-lane commit record typedef {commit, is_event, pc_alter, wb};
  - lane-count limits;
  - the PC increment constants 2 and 4.
- Sub-module wb_lane_eval: combinational, one instance per lane. Computes is_event, redirect target, and the raw register write.
- The top level handles:
  - priority/squash;
  - WAW masking;
  - shadow counter;
  - counters;
  - output registers.

Test Plan:
1. NUM_LANES=2, lane0 writes x5=0x11 and lane1 writes x6=0x22, no events -> next cycle both wb valid with matching idx/data; o_instret += 2.
2. Lane0 EXCEPT_MISPRED with i_data=0x8000_0100, lane1 writes x7 -> o_flush=1, o_pc_alter=1, o_pc=0x8000_0100; lane1 squashed; instret += 1.
3. Lane1 EXCEPT_FLUSH at pc 0x200, half=1, lane0 valid -> o_pc=0x202, lane0 commits; then with FLUSH_SHADOW=3, valid bundles in the following 3 cycles produce all-zero outputs and instret unchanged.
4. Both lanes write x9 (0xA, 0xB) -> only lane1 wb valid, data 0xB; lane0 wb valid=0; instret += 2.
5. Lane0 rd_sel=RD_REG_AND_PC at pc 0x400, half=0, rd=x1 -> wb data 0x404; a write with rd=x0 produces no wb valid.
6. Assert i_rst_n low asynchronously mid-shadow with counters nonzero -> all outputs and counters 0 before the next clock edge; normal commit on the first edge after release.
